// File: rtl/mcp320x_array.sv
// mcp320x_array: shared-SCLK/shared-CS controller for N MCP3201-class ADCs,
// with optional 2^AVG_LOG2 frame averaging and a valid/ready result port.
module mcp320x_array #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 12,
    parameter int LEAD_CLKS  = 3,
    parameter int RELAX_CLKS = 2,
    parameter int AVG_LOG2   = 0
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable_i,
    input  logic                           spi_clk_i,
    output logic                           spi_ssn_o,
    input  logic [CHANNELS-1:0]            spi_miso_i,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           overrun_o,
    input  logic                           overrun_clr_i
);
    localparam int AW = DATA_WIDTH + AVG_LOG2;
    localparam int RW = $clog2(RELAX_CLKS + 1);
    localparam int BW = $clog2(LEAD_CLKS + DATA_WIDTH);
    localparam logic [RW-1:0]     RELAX_MAX = RW'(RELAX_CLKS);
    localparam logic [RW-1:0]     RELAX_PRE = RW'(RELAX_CLKS - 1);
    localparam logic [BW-1:0]     BIT_LEAD  = BW'(LEAD_CLKS);
    localparam logic [BW-1:0]     BIT_LAST  = BW'(LEAD_CLKS + DATA_WIDTH - 1);
    localparam logic [AVG_LOG2:0] AVG_LAST  = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {RELAX, SHIFT, ACCUM, OUTPUT} state_t;

    state_t                         r_state, w_state_nxt;
    logic                           r_sclk_q, r_ssn, r_valid, r_overrun;
    logic [RW-1:0]                  r_relax_cnt;
    logic [BW-1:0]                  r_bit_cnt;
    logic [AVG_LOG2:0]              r_avg_cnt;
    logic [DATA_WIDTH-1:0]          r_sr [CHANNELS];
    logic [AW-1:0]                  r_acc [CHANNELS];
    logic [CHANNELS*DATA_WIDTH-1:0] r_data;
    logic                           w_edge, w_start, w_last, w_avg_done, w_new, w_acc_clr;

    assign w_edge     = spi_clk_i & ~r_sclk_q;
    // relax_cnt saturates, so any edge after the relax window also qualifies
    assign w_start    = (r_state == RELAX) && w_edge && enable_i && (r_relax_cnt >= RELAX_PRE);
    assign w_last     = (r_state == SHIFT) && w_edge && (r_bit_cnt == BIT_LAST);
    assign w_avg_done = r_avg_cnt == AVG_LAST;
    assign w_new      = r_state == OUTPUT;
    assign w_acc_clr  = w_new || ((r_state == RELAX) && !enable_i);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RELAX:   w_state_nxt = w_start ? SHIFT : RELAX;
            SHIFT:   w_state_nxt = w_last ? ACCUM : SHIFT;
            ACCUM:   w_state_nxt = w_avg_done ? OUTPUT : RELAX;
            default: w_state_nxt = RELAX;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= RELAX;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_q    <= 1'b0;
            r_ssn       <= 1'b1;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_relax_cnt <= '0;
            r_bit_cnt   <= '0;
            r_avg_cnt   <= '0;
            r_data      <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_sr[k]  <= '0;
                r_acc[k] <= '0;
            end
        end else begin
            r_sclk_q <= spi_clk_i;
            if ((r_state == RELAX) && w_edge && (r_relax_cnt != RELAX_MAX))
                r_relax_cnt <= r_relax_cnt + 1'b1;
            if (w_start) begin
                r_ssn     <= 1'b0;
                r_bit_cnt <= '0;
            end
            if ((r_state == SHIFT) && w_edge) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt >= BIT_LEAD)
                    for (int k = 0; k < CHANNELS; k++)
                        r_sr[k] <= {r_sr[k][DATA_WIDTH-2:0], spi_miso_i[k]};
                if (w_last) begin
                    r_ssn       <= 1'b1;
                    r_relax_cnt <= '0;
                end
            end
            if (r_state == ACCUM) begin
                r_avg_cnt <= r_avg_cnt + 1'b1;
                for (int k = 0; k < CHANNELS; k++)
                    r_acc[k] <= r_acc[k] + AW'(r_sr[k]);
            end else if (w_acc_clr) begin
                r_avg_cnt <= '0;
                for (int k = 0; k < CHANNELS; k++)
                    r_acc[k] <= '0;
            end
            if (w_new)
                for (int k = 0; k < CHANNELS; k++)
                    r_data[k*DATA_WIDTH +: DATA_WIDTH] <= r_acc[k][AW-1:AVG_LOG2];
            r_valid   <= w_new ? 1'b1 : (ready_i ? 1'b0 : r_valid);
            // a set from an unaccepted overwrite beats a simultaneous clear
            r_overrun <= (w_new && r_valid && !ready_i) ? 1'b1 : (overrun_clr_i ? 1'b0 : r_overrun);
        end
    end

    assign spi_ssn_o = r_ssn;
    assign data_o    = r_data;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;
endmodule

// File: tb/tb_mcp320x_array.sv
// tb_mcp320x_array: directed bench with behavioural MCP3201 models for three
// configurations (defaults, 4-frame averaging, 4 x 10-bit).
module tb_mcp320x_array;
    logic        clock = 1'b0, rst_n = 1'b1, spi_clk = 1'b0;
    logic        en_a, en_b, en_c, rdy_a, rdy_b, rdy_c, clr_a, clr_b, clr_c;
    logic        ssn_a, ssn_b, ssn_c, valid_a, valid_b, valid_c, ovr_a, ovr_b, ovr_c;
    logic [1:0]  miso_a = '0, miso_b = '0;
    logic [3:0]  miso_c = '0;
    logic [23:0] data_a, data_b;
    logic [39:0] data_c;
    logic [11:0] adc_a [2];
    logic [11:0] adc_b [2];
    logic [11:0] adc_c [4];
    int          rc_a = 0, rc_b = 0, rc_c = 0, rises = 0, fall_mark = 0, sdiv = 0;
    int          period_a = 0, low_a = 0, low_c = 0, vcount_b = 0;
    logic        pa = 1'b1, pc = 1'b1, pvb = 1'b0, seen;
    int          n_chk = 0, n_pass = 0;

    always #5 clock = ~clock;

    mcp320x_array u_a (
        .clock(clock), .reset_n(rst_n), .enable_i(en_a), .spi_clk_i(spi_clk),
        .spi_ssn_o(ssn_a), .spi_miso_i(miso_a), .data_o(data_a), .valid_o(valid_a),
        .ready_i(rdy_a), .overrun_o(ovr_a), .overrun_clr_i(clr_a)
    );

    mcp320x_array #(.AVG_LOG2(2)) u_b (
        .clock(clock), .reset_n(rst_n), .enable_i(en_b), .spi_clk_i(spi_clk),
        .spi_ssn_o(ssn_b), .spi_miso_i(miso_b), .data_o(data_b), .valid_o(valid_b),
        .ready_i(rdy_b), .overrun_o(ovr_b), .overrun_clr_i(clr_b)
    );

    mcp320x_array #(.CHANNELS(4), .DATA_WIDTH(10)) u_c (
        .clock(clock), .reset_n(rst_n), .enable_i(en_c), .spi_clk_i(spi_clk),
        .spi_ssn_o(ssn_c), .spi_miso_i(miso_c), .data_o(data_c), .valid_o(valid_c),
        .ready_i(rdy_c), .overrun_o(ovr_c), .overrun_clr_i(clr_c)
    );

    // ADC bit presented before rise r of a frame: 3 lead clocks, then MSB first
    function automatic logic bitval(input int dw, input logic [11:0] d, input int r);
        if (r >= 3 && r < 3 + dw) return d[dw-1-(r-3)];
        return 1'b0;
    endfunction

    function automatic logic ssn_of(input int w);
        return (w == 0) ? ssn_a : ((w == 1) ? ssn_b : ssn_c);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_ssn(input int w, input logic lvl, input string tag);
        int n = 0;
        while (ssn_of(w) !== lvl && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk(tag, ssn_of(w), lvl);
    endtask

    // SCLK with a 4-clock half period; ADC models update MISO on falling SCLK
    always @(negedge clock) begin
        if (sdiv == 3) begin
            sdiv = 0;
            spi_clk = ~spi_clk;
            if (spi_clk) begin
                rises++;
                if (!ssn_a) rc_a++;
                if (!ssn_b) rc_b++;
                if (!ssn_c) rc_c++;
            end else begin
                for (int k = 0; k < 2; k++) miso_a[k] = bitval(12, adc_a[k], rc_a);
                for (int k = 0; k < 2; k++) miso_b[k] = bitval(12, adc_b[k], rc_b);
                for (int k = 0; k < 4; k++) miso_c[k] = bitval(10, adc_c[k], rc_c);
            end
        end else begin
            sdiv++;
        end
        if (ssn_a && !pa) low_a = rc_a;
        if (!ssn_a && pa) begin
            period_a = rises - fall_mark;
            fall_mark = rises;
        end
        if (ssn_c && !pc) low_c = rc_c;
        if (valid_b && !pvb) vcount_b++;
        if (ssn_a) rc_a = 0;
        if (ssn_b) rc_b = 0;
        if (ssn_c) rc_c = 0;
        pa = ssn_a;
        pc = ssn_c;
        pvb = valid_b;
    end

    initial begin
        en_a = 0; en_b = 0; en_c = 0; rdy_a = 1; rdy_b = 1; rdy_c = 1;
        clr_a = 0; clr_b = 0; clr_c = 0;
        adc_a[0] = 12'hABC; adc_a[1] = 12'h123;
        adc_b[0] = 12'd100; adc_b[1] = 12'd200;
        adc_c[0] = 12'h3FF; adc_c[1] = 12'h000; adc_c[2] = 12'h2AA; adc_c[3] = 12'h155;
        #2 rst_n = 0;
        repeat (3) @(negedge clock);
        chk("rst ssn", ssn_a, 1);
        chk("rst valid", valid_a, 0);
        chk("rst ovr", ovr_a, 0);
        chk("rst data", data_a, 0);
        rst_n = 1;
        en_a = 1;
        wait_ssn(0, 0, "f1 start");
        wait_ssn(0, 1, "f1 end");
        chk("lat +0", valid_a, 0);
        @(negedge clock); chk("lat +1", valid_a, 0);
        @(negedge clock); chk("lat +2", valid_a, 1);
        chk("f1 data", data_a, 24'h123ABC);
        @(negedge clock); chk("pulse", valid_a, 0);
        chk("ssn low edges", low_a, 15);
        chk("f1 ovr", ovr_a, 0);
        wait_ssn(0, 0, "f2 start");
        @(negedge clock); chk("period", period_a, 17);
        wait_ssn(0, 1, "f2 end");
        adc_a[0] = 12'h100;
        repeat (3) @(negedge clock);
        chk("f2 pulse done", valid_a, 0);
        rdy_a = 0;
        wait_ssn(0, 0, "o1 start");
        wait_ssn(0, 1, "o1 end");
        repeat (2) @(negedge clock);
        chk("o1 valid", valid_a, 1);
        chk("o1 data", data_a, 24'h123100);
        chk("o1 ovr", ovr_a, 0);
        adc_a[0] = 12'h200;
        wait_ssn(0, 0, "o2 start");
        wait_ssn(0, 1, "o2 end");
        repeat (2) @(negedge clock);
        chk("o2 valid", valid_a, 1);
        chk("o2 data", data_a, 24'h123200);
        chk("o2 ovr", ovr_a, 1);
        rdy_a = 1;
        @(negedge clock); rdy_a = 0;
        chk("accept", valid_a, 0);
        chk("ovr held", ovr_a, 1);
        clr_a = 1;
        @(negedge clock); clr_a = 0;
        chk("ovr clr", ovr_a, 0);
        rdy_a = 1;
        adc_a[0] = 12'h5A5;
        wait_ssn(0, 0, "e start");
        for (int n = 0; n < 200 && rc_a != 5; n++) @(negedge clock);
        chk("e bit5", rc_a, 5);
        en_a = 0;
        wait_ssn(0, 1, "e end");
        repeat (2) @(negedge clock);
        chk("e valid", valid_a, 1);
        chk("e data", data_a, 24'h1235A5);
        seen = 0;
        repeat (400) begin
            @(negedge clock);
            if (!ssn_a) seen = 1;
        end
        chk("e idle", seen, 0);
        en_a = 1;
        for (int n = 0; n < 10 && ssn_a; n++) @(negedge clock);
        chk("e restart", ssn_a, 0);
        rdy_a = 0;
        wait_ssn(0, 1, "r prev end");
        repeat (3) @(negedge clock);
        chk("r prev valid", valid_a, 1);
        wait_ssn(0, 0, "r start");
        repeat (48) @(negedge clock);
        chk("r mid ssn", ssn_a, 0);
        @(posedge clock);
        #2 rst_n = 0;
        #1;
        chk("r ssn", ssn_a, 1);
        chk("r valid", valid_a, 0);
        chk("r data", data_a, 0);
        @(negedge clock);
        rst_n = 1;
        rdy_a = 1;
        wait_ssn(0, 0, "r f start");
        wait_ssn(0, 1, "r f end");
        repeat (2) @(negedge clock);
        chk("r f valid", valid_a, 1);
        chk("r f data", data_a, 24'h1235A5);
        en_a = 0;
        en_b = 1;
        wait_ssn(1, 0, "a1 start");
        wait_ssn(1, 1, "a1 end");
        adc_b[0] = 12'd101;
        wait_ssn(1, 0, "a2 start");
        wait_ssn(1, 1, "a2 end");
        adc_b[0] = 12'd102;
        wait_ssn(1, 0, "a3 start");
        wait_ssn(1, 1, "a3 end");
        adc_b[0] = 12'd104;
        repeat (3) @(negedge clock);
        chk("avg early", vcount_b, 0);
        wait_ssn(1, 0, "a4 start");
        wait_ssn(1, 1, "a4 end");
        repeat (2) @(negedge clock);
        chk("avg valid", valid_b, 1);
        chk("avg data", data_b, {12'd200, 12'd101});
        en_b = 0;
        @(negedge clock); chk("avg count", vcount_b, 1);
        en_c = 1;
        wait_ssn(2, 0, "w start");
        wait_ssn(2, 1, "w end");
        repeat (2) @(negedge clock);
        chk("w valid", valid_c, 1);
        chk("w data", data_c, {10'h155, 10'h2AA, 10'h000, 10'h3FF});
        chk("w low edges", low_c, 13);
        en_c = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
